alu_seq: RTL and testbench

Parametrised, handshaked successor to the single-cycle execute-stage ALU. Adds SLT/SLTU/SRA, signed-overflow detection and iterative multiply/divide/remainder, all behind one valid/ready operand interface and one valid/ready result interface. It sits in the execute stage. The core stalls on `in_ready`/`out_valid`, so multi-cycle ops are transparent to the pipeline.

---
 rtl/alu_seq_if.sv | 28 ++
 rtl/alu_seq.sv | 196 +++++++++++++++++++
 tb/tb_alu_seq.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Operand and result handshake bundle for alu_seq.
// master drives operands and out_ready; slave returns result and flags.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             sign;
  logic             overflow;
  logic             busy;

  modport master (
    output in_valid, op, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, zero, sign, overflow, busy
  );

  modport slave (
    input  in_valid, op, src_a, src_b, out_ready,
    output in_ready, out_valid, result, zero, sign, overflow, busy
  );
endinterface

// File: rtl/alu_seq.sv
// Handshaked execute-stage ALU: single-cycle logic/arith ops plus
// iterative shift-add multiply and restoring divide/remainder.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input logic clk,
  input logic rst,
  alu_seq_if.slave bus
);
  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;
  localparam int M  = WIDTH - 1;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SLL   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_SLT   = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SRL   = 4'd5;
  localparam logic [3:0] OP_OR    = 4'd6;
  localparam logic [3:0] OP_AND   = 4'd7;
  localparam logic [3:0] OP_SRA   = 4'd8;
  localparam logic [3:0] OP_SLTU  = 4'd9;
  localparam logic [3:0] OP_MUL   = 4'd10;
  localparam logic [3:0] OP_MULHU = 4'd11;
  localparam logic [3:0] OP_DIV   = 4'd12;
  localparam logic [3:0] OP_DIVU  = 4'd13;
  localparam logic [3:0] OP_REM   = 4'd14;
  localparam logic [3:0] OP_REMU  = 4'd15;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {M{1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state;
  logic [3:0]         op_q;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] nxt;
  logic [WIDTH-1:0]   dvs;
  logic [CW-1:0]      cnt;
  logic               neg_q;
  logic               neg_r;
  logic               dz;
  logic               dov;

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [SW-1:0]    sh;
  logic             is_mul;
  logic             is_sdiv;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  assign a       = bus.src_a;
  assign b       = bus.src_b;
  assign sh      = b[SW-1:0];
  assign is_mul  = (bus.op == OP_MUL) || (bus.op == OP_MULHU);
  assign is_sdiv = (bus.op == OP_DIV) || (bus.op == OP_REM);
  assign abs_a   = (is_sdiv && a[M]) ? -a : a;
  assign abs_b   = (is_sdiv && b[M]) ? -b : b;

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state == BUSY);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] dif;
  logic [WIDTH-1:0] alu_r;
  logic             alu_v;

  assign sum = a + b;
  assign dif = a - b;

  always_comb begin
    alu_r = '0;
    alu_v = 1'b0;
    case (bus.op)
      OP_ADD: begin
        alu_r = sum;
        alu_v = (a[M] == b[M]) && (sum[M] != a[M]);
      end
      OP_SUB: begin
        alu_r = dif;
        alu_v = (a[M] != b[M]) && (dif[M] != a[M]);
      end
      OP_SLL:  alu_r = a << sh;
      OP_SLT:  alu_r = {{M{1'b0}}, $signed(a) < $signed(b)};
      OP_XOR:  alu_r = a ^ b;
      OP_SRL:  alu_r = a >> sh;
      OP_OR:   alu_r = a | b;
      OP_AND:  alu_r = a & b;
      OP_SRA:  alu_r = $signed(a) >>> sh;
      OP_SLTU: alu_r = {{M{1'b0}}, a < b};
      default: alu_r = '0;
    endcase
  end

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH:0]   div_df;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] fin;

  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]}
                 + (acc[0] ? {1'b0, dvs} : '0);
  assign div_sh  = acc[2*WIDTH-1:WIDTH-1];
  assign div_df  = div_sh - {1'b0, dvs};

  always_comb begin
    nxt = {acc[2*WIDTH-2:0], 1'b0};
    if (op_q == OP_MUL || op_q == OP_MULHU)
      nxt = {mul_sum, acc[WIDTH-1:1]};
    else if (!div_df[WIDTH])
      nxt = {div_df[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end

  assign quo = nxt[WIDTH-1:0];
  assign rem = nxt[2*WIDTH-1:WIDTH];

  always_comb begin
    fin = '0;
    case (op_q)
      OP_MUL:   fin = quo;
      OP_MULHU: fin = rem;
      OP_DIV: begin
        if (dz)        fin = '1;
        else if (dov)  fin = MIN_NEG;
        else           fin = neg_q ? -quo : quo;
      end
      OP_DIVU:  fin = quo;
      OP_REM:   fin = dov ? '0 : (neg_r ? -rem : rem);
      OP_REMU:  fin = rem;
      default:  fin = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      op_q         <= '0;
      acc          <= '0;
      dvs          <= '0;
      cnt          <= '0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      dz           <= 1'b0;
      dov          <= 1'b0;
      bus.result   <= '0;
      bus.zero     <= 1'b0;
      bus.sign     <= 1'b0;
      bus.overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            op_q <= bus.op;
            if (bus.op < OP_MUL) begin
              bus.result   <= alu_r;
              bus.zero     <= (alu_r == '0);
              bus.sign     <= alu_r[M];
              bus.overflow <= alu_v;
              state        <= DONE;
            end else begin
              acc   <= {{WIDTH{1'b0}}, is_mul ? a : abs_a};
              dvs   <= is_mul ? b : abs_b;
              cnt   <= CW'(WIDTH);
              neg_q <= is_sdiv && (a[M] ^ b[M]);
              neg_r <= is_sdiv && a[M];
              dz    <= (b == '0);
              dov   <= is_sdiv && (a == MIN_NEG) && (b == '1);
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          acc <= nxt;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            bus.result   <= fin;
            bus.zero     <= (fin == '0);
            bus.sign     <= fin[M];
            bus.overflow <= 1'b0;
            state        <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Randomised and directed bench for alu_seq against an arithmetic
// reference model.
module tb_alu_seq;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model(input logic [3:0] op,
                                input logic [31:0] a,
                                input logic [31:0] b,
                                output logic [31:0] r,
                                output logic v);
    longint sa, sb, s, q;
    logic [63:0] p;
    int sh;
    sa = $signed(a);
    sb = $signed(b);
    sh = int'(b[4:0]);
    p  = {32'b0, a} * {32'b0, b};
    v  = 1'b0;
    r  = '0;
    case (op)
      4'd0: begin
        s = sa + sb;
        r = s[31:0];
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd1: r = a << sh;
      4'd2: begin
        s = sa - sb;
        r = s[31:0];
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd3: r = (sa < sb) ? 32'd1 : 32'd0;
      4'd4: r = a ^ b;
      4'd5: r = a >> sh;
      4'd6: r = a | b;
      4'd7: r = a & b;
      4'd8: r = $signed(a) >>> sh;
      4'd9: r = (a < b) ? 32'd1 : 32'd0;
      4'd10: r = p[31:0];
      4'd11: r = p[63:32];
      4'd12: begin
        if (b == 0) r = '1;
        else if (a == 32'h80000000 && b == '1) r = 32'h80000000;
        else begin
          q = sa / sb;
          r = q[31:0];
        end
      end
      4'd13: r = (b == 0) ? '1 : a / b;
      4'd14: begin
        if (b == 0) r = a;
        else if (a == 32'h80000000 && b == '1) r = 0;
        else begin
          q = sa % sb;
          r = q[31:0];
        end
      end
      default: r = (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic run_op(input logic [3:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input int stall);
    logic [31:0] er;
    logic ev;
    int lat, nb, want;
    model(op, a, b, er, ev);
    for (int i = 0; i < 50 && !bus.in_ready; i++) tick();
    check($sformatf("op%0d in_ready", op), bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.src_a    = a;
    bus.src_b    = b;
    tick();
    bus.in_valid = 1'b0;
    bus.src_a    = $urandom;
    bus.src_b    = $urandom;
    lat = 1;
    nb  = 0;
    while (!bus.out_valid && lat < 100) begin
      nb += int'(bus.busy);
      tick();
      lat++;
    end
    want = (op >= 4'd10) ? W + 1 : 1;
    check($sformatf("op%0d latency", op), lat, want);
    check($sformatf("op%0d busy", op), nb, want - 1);
    check($sformatf("op%0d %h,%h result", op, a, b), bus.result, er);
    check($sformatf("op%0d zero", op), bus.zero, er == 0);
    check($sformatf("op%0d sign", op), bus.sign, er[31]);
    check($sformatf("op%0d overflow", op), bus.overflow, ev);
    repeat (stall) tick();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'($urandom_range(0, 9));
      4:       return -32'($urandom_range(1, 9));
      default: return $urandom;
    endcase
  endfunction

  logic seen;

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.op        = '0;
    bus.src_a     = '0;
    bus.src_b     = '0;
    repeat (2) tick();
    check("rst out_valid", bus.out_valid, 0);
    check("rst result", bus.result, 0);
    check("rst flags", {bus.zero, bus.sign, bus.overflow}, 0);
    check("rst busy", bus.busy, 0);
    check("rst in_ready", bus.in_ready, 0);
    rst = 1'b0;
    #1;
    check("rel in_ready", bus.in_ready, 1);

    run_op(4'd0, 32'h7FFFFFFF, 32'h1, 0);
    run_op(4'd2, 32'd5, 32'd5, 0);
    run_op(4'd8, 32'h80000000, 32'h3F, 0);
    run_op(4'd9, 32'd1, 32'hFFFFFFFF, 0);
    run_op(4'd3, 32'd1, 32'hFFFFFFFF, 0);
    run_op(4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    run_op(4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    run_op(4'd12, -32'd7, 32'd2, 0);
    run_op(4'd14, -32'd7, 32'd2, 0);
    run_op(4'd13, 32'd7, 32'd0, 0);
    run_op(4'd15, 32'd7, 32'd0, 0);
    run_op(4'd12, 32'h80000000, 32'hFFFFFFFF, 0);
    run_op(4'd14, 32'h80000000, 32'hFFFFFFFF, 0);
    run_op(4'd12, -32'd9, 32'd0, 0);
    run_op(4'd14, -32'd9, 32'd0, 1);

    // backpressure: held result must not move and new operands are ignored
    run_op(4'd0, 32'd3, 32'd4, 0);
    bus.in_valid = 1'b1;
    bus.op       = 4'd0;
    bus.src_a    = 32'd3;
    bus.src_b    = 32'd4;
    for (int i = 0; i < 50 && !bus.in_ready; i++) tick();
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        bus.in_valid = 1'b1;
        bus.op       = 4'd2;
        bus.src_a    = $urandom;
      end
      check("bp out_valid", bus.out_valid, 1);
      check("bp result", bus.result, 32'd7);
      check("bp flags", {bus.zero, bus.sign, bus.overflow}, 0);
      check("bp in_ready", bus.in_ready, 0);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("bp in_ready after", bus.in_ready, 1);
    check("bp out_valid after", bus.out_valid, 0);
    seen = 1'b0;
    repeat (3) begin
      seen |= bus.out_valid;
      tick();
    end
    check("bp ignored op", seen, 0);

    for (int n = 0; n < 250; n++)
      run_op(4'($urandom_range(0, 15)), pick(), pick(),
             int'($urandom_range(0, 2)));

    // reset in the middle of an iterative op
    run_op(4'd0, 32'd1, 32'd2, 0);
    bus.in_valid = 1'b1;
    bus.op       = 4'd10;
    bus.src_a    = 32'd6;
    bus.src_b    = 32'd7;
    tick();
    bus.in_valid = 1'b0;
    repeat (5) tick();
    check("mid busy", bus.busy, 1);
    rst = 1'b1;
    tick();
    check("abort out_valid", bus.out_valid, 0);
    check("abort result", bus.result, 0);
    check("abort flags", {bus.zero, bus.sign, bus.overflow}, 0);
    check("abort busy", bus.busy, 0);
    check("abort in_ready", bus.in_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    check("abort rel in_ready", bus.in_ready, 1);
    seen = 1'b0;
    repeat (40) begin
      seen |= bus.out_valid;
      tick();
    end
    check("abort no result", seen, 0);
    run_op(4'd13, 32'd100, 32'd7, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
